hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline sequencing unit that sits beside the forwarding unit and drives the stall, flush and write-enable controls for PC, IF/ID, ID/EX and EX/MEM.
- Covers hazards that forwarding cannot hide: load-use, branch-in-ID operand dependencies, taken branch/jump redirect, the multi-cycle mult/div occupancy of EX, and exception flush.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- MD_CYCLES, 8: total stall cycles charged to one mult/div op in EX; legal range is 2 or more.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Rs_ID, Rt_ID  in  5 each  source register numbers of the instruction in ID.
- uses_rs, uses_rt  in  1 each  the ID instruction actually reads Rs / Rt.
- is_branch_ID  in  1  ID instruction compares operands in ID (beq/bne/jr class).
- branch_taken  in  1  branch resolved taken in ID.
- jump_ID  in  1  unconditional jump in ID.
- Address_ID_EX  in  5  destination register in ID/EX.
- RegWrite_ID_EX, MemRead_ID_EX  in  1 each  write / load flags in ID/EX.
- Address_EX_MEM  in  5  destination register in EX/MEM.
- RegWrite_EX_MEM, MemRead_EX_MEM  in  1 each  write / load flags in EX/MEM.
- md_start  in  1  mult/div op present in EX.
- exc_req  in  1  exception/interrupt raised in MEM.
- PC_Write  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID update enable.
- ID_EX_Write  out  1  ID/EX update enable.
- IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush  out  1 each  insert a bubble into the named register.
- exc_pc_sel  out  1  PC source = exception vector.
- md_done  out  1  one-cycle pulse; the mult/div result advances this cycle.
- stall_count  out  CNT_W  number of cycles with PC_Write=0.

Behaviour:
- Reset: clk is the only clock. reset is asynchronous and active-high.
  - While reset is high, all outputs are 0, including PC_Write and every write enable.
  - FSM goes to RUN, the internal counter md_cnt goes to 0 and stall_count goes to 0.
- Defaults when not in reset: PC_Write=IF_ID_Write=ID_EX_Write=1; every flush, exc_pc_sel and md_done = 0.
- States: RUN, MD_BUSY. md_cnt is ceil(log2(MD_CYCLES)) bits wide.
- Dependency match: register fields equal, register is nonzero, and the corresponding uses_* bit is set.
- Forwarding limits: ID-stage forwarding supplies Rs from EX/MEM or MEM/WB, and Rt from MEM/WB only.
- Priority 1, exc_req (any state): IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush and exc_pc_sel are all 1; PC_Write=1. Next state RUN, md_cnt cleared. An in-flight mult/div is aborted and md_done stays 0.
- Priority 2, RUN with md_start: PC_Write=IF_ID_Write=ID_EX_Write=0 and EX_MEM_Flush=1. md_cnt is loaded with MD_CYCLES-1 and the next state is MD_BUSY.
- MD_BUSY with md_cnt != 0: same holds as priority 2; md_cnt decrements.
- MD_BUSY with md_cnt == 0: no holds, md_done=1, next state RUN. The EX op advances and md_start is not re-sampled in this cycle.
- Total stall for one mult/div op is exactly MD_CYCLES cycles.
- Priority 3, data stall in RUN (holds PC and IF/ID, ID_EX_Flush=1). Any of the following triggers it:
  - Load-use: MemRead_ID_EX and the ID/EX destination matches Rs or Rt.
  - Branch on ALU result in ID/EX: is_branch_ID, RegWrite_ID_EX and the ID/EX destination matches Rs or Rt.
  - Branch on load in EX/MEM: is_branch_ID, MemRead_EX_MEM and the EX/MEM destination matches Rs or Rt.
  - Branch Rt on EX/MEM ALU result: is_branch_ID, RegWrite_EX_MEM and the EX/MEM destination matches Rt.
- Stall lengths from the rules above:
  - A branch depending on a load in ID/EX stalls 2 cycles.
  - A branch depending on an ALU result in ID/EX stalls 1 cycle, or 2 cycles when the dependency is through Rt.
  - A non-branch load-use stalls 1 cycle.
- Priority 4, control redirect in RUN: if branch_taken or jump_ID, IF_ID_Flush=1. It is ignored in any cycle with a higher-priority hold, because the branch outcome is not valid then.
- Performance counter: stall_count increments on each clock edge where PC_Write=0 and reset is low. It saturates at all-ones.
- Exception-flush cycles do not count as stalls.

Decomposition:
- Package hazard_pkg holds:
  - the state enum (RUN=1'b0, MD_BUSY=1'b1);
  - the MD_CYCLES default;
  - the register-number width constant (5).
- Natural sub-module: hazard_detect. It is purely combinational and produces the data_stall flag from the register fields; the FSM, counters and priority mux stay in the top level.

Test Plan:
- Load-use: lw $8 in ID/EX, add $9,$8,$1 in ID (uses_rs=1, Rs_ID=8) -> exactly 1 cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; stall_count 0->1.
- Branch on load: beq $8,$0 right after lw $8 -> 2 stall cycles (first via MemRead_ID_EX, then via MemRead_EX_MEM); then branch_taken=1 -> IF_ID_Flush=1 for exactly 1 cycle.
- Register-zero guard: lw $0 in ID/EX, consumer with Rs_ID=0 -> no stall; PC_Write stays 1.
- Mult/div with MD_CYCLES=8: md_start high from cycle 0 -> holds during cycles 0-7, md_done=1 at cycle 8, stall_count=8.
- Exception abort: exc_req at cycle 3 of MD_BUSY -> all three flushes and exc_pc_sel=1 that cycle; state RUN next cycle; md_done never pulses.
- Async reset: assert reset mid-MD_BUSY between clock edges -> all outputs 0 immediately; after release, state RUN and stall_count=0. Separately, preload stall_count near all-ones and stall -> it saturates.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Register-number width of the architectural register file.
    localparam int REG_W = 5;

    // Default number of stall cycles charged to one mult/div op in EX.
    localparam int MD_CYCLES_DEF = 8;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    // A consumer depends on a producer when the register fields match,
    // the register is not $0, and the consumer actually reads that source.
    function automatic logic reg_match(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] dst,
        input logic             uses
    );
        return uses && (src == dst) && (src != '0);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational data-hazard detector: flags dependencies that forwarding
// cannot cover (load-use and branch-in-ID operand hazards).
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] Rs_ID,
    input  logic [REG_W-1:0] Rt_ID,
    input  logic             uses_rs,
    input  logic             uses_rt,
    input  logic             is_branch_ID,
    input  logic [REG_W-1:0] Address_ID_EX,
    input  logic             RegWrite_ID_EX,
    input  logic             MemRead_ID_EX,
    input  logic [REG_W-1:0] Address_EX_MEM,
    input  logic             RegWrite_EX_MEM,
    input  logic             MemRead_EX_MEM,
    output logic             data_stall
);

    logic rs_id_ex;
    logic rt_id_ex;
    logic rs_ex_mem;
    logic rt_ex_mem;
    logic load_use;
    logic br_alu_id_ex;
    logic br_load_ex_mem;
    logic br_rt_alu_ex_mem;

    // Match each ID source against the ID/EX and EX/MEM destinations and
    // combine into the stall conditions. ID-stage forwarding gives Rs from
    // EX/MEM but Rt only from MEM/WB, hence the Rt-only EX/MEM ALU case.
    always_comb begin
        rs_id_ex         = reg_match(Rs_ID, Address_ID_EX, uses_rs);
        rt_id_ex         = reg_match(Rt_ID, Address_ID_EX, uses_rt);
        rs_ex_mem        = reg_match(Rs_ID, Address_EX_MEM, uses_rs);
        rt_ex_mem        = reg_match(Rt_ID, Address_EX_MEM, uses_rt);

        load_use         = MemRead_ID_EX && (rs_id_ex || rt_id_ex);
        br_alu_id_ex     = is_branch_ID && RegWrite_ID_EX && (rs_id_ex || rt_id_ex);
        br_load_ex_mem   = is_branch_ID && MemRead_EX_MEM && (rs_ex_mem || rt_ex_mem);
        br_rt_alu_ex_mem = is_branch_ID && RegWrite_EX_MEM && rt_ex_mem;

        data_stall = load_use || br_alu_id_ex || br_load_ex_mem || br_rt_alu_ex_mem;
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing unit: drives PC / pipeline-register write enables and
// flushes for data hazards, redirects, mult/div occupancy and exceptions,
// and keeps a saturating stall-cycle counter.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEF,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] Rs_ID,
    input  logic [REG_W-1:0] Rt_ID,
    input  logic             uses_rs,
    input  logic             uses_rt,
    input  logic             is_branch_ID,
    input  logic             branch_taken,
    input  logic             jump_ID,
    input  logic [REG_W-1:0] Address_ID_EX,
    input  logic             RegWrite_ID_EX,
    input  logic             MemRead_ID_EX,
    input  logic [REG_W-1:0] Address_EX_MEM,
    input  logic             RegWrite_EX_MEM,
    input  logic             MemRead_EX_MEM,
    input  logic             md_start,
    input  logic             exc_req,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             exc_pc_sel,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_count
);

    localparam int MD_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             data_stall;
    logic             md_hold;

    hazard_detect u_detect (
        .Rs_ID           (Rs_ID),
        .Rt_ID           (Rt_ID),
        .uses_rs         (uses_rs),
        .uses_rt         (uses_rt),
        .is_branch_ID    (is_branch_ID),
        .Address_ID_EX   (Address_ID_EX),
        .RegWrite_ID_EX  (RegWrite_ID_EX),
        .MemRead_ID_EX   (MemRead_ID_EX),
        .Address_EX_MEM  (Address_EX_MEM),
        .RegWrite_EX_MEM (RegWrite_EX_MEM),
        .MemRead_EX_MEM  (MemRead_EX_MEM),
        .data_stall      (data_stall)
    );

    // State, mult/div countdown and stall counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            md_cnt_q      <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            md_cnt_q      <= md_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Next-state: exception aborts everything; otherwise mult/div sequencing.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        if (exc_req) begin
            state_d  = RUN;
            md_cnt_d = '0;
        end else if (state_q == RUN) begin
            if (md_start) begin
                state_d  = MD_BUSY;
                md_cnt_d = MD_LOAD;
            end
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_W'(1);
        end else begin
            state_d = RUN;
        end
    end

    // Mult/div occupancy hold: the issue cycle plus every busy cycle but the last.
    always_comb begin
        md_hold = (state_q == RUN) ? md_start : (md_cnt_q != '0);
    end

    // Output priority mux: exception > mult/div > data stall > redirect.
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        exc_pc_sel   = 1'b0;
        md_done      = 1'b0;
        if (reset) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Write = 1'b0;
        end else if (exc_req) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            exc_pc_sel   = 1'b1;
        end else if (md_hold) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Flush = 1'b1;
        end else if (state_q == MD_BUSY) begin
            md_done = 1'b1;
        end else if (data_stall) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end else if (branch_taken || jump_ID) begin
            IF_ID_Flush = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_comb begin
        stall_count_d = stall_count_q;
        if (!PC_Write && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller; a second instance with a
// narrow counter exercises saturation.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs_ID, Rt_ID, Address_ID_EX, Address_EX_MEM;
    logic       uses_rs, uses_rt, is_branch_ID, branch_taken, jump_ID;
    logic       RegWrite_ID_EX, MemRead_ID_EX, RegWrite_EX_MEM, MemRead_EX_MEM;
    logic       md_start, exc_req;

    logic        PC_Write, IF_ID_Write, ID_EX_Write;
    logic        IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, exc_pc_sel, md_done;
    logic [31:0] stall_count;

    logic        s_pc, s_ifw, s_idw, s_iff, s_idf, s_exf, s_exc, s_done;
    logic [3:0]  s_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_controller u_dut (
        .clk(clk), .reset(reset),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .uses_rs(uses_rs), .uses_rt(uses_rt),
        .is_branch_ID(is_branch_ID), .branch_taken(branch_taken), .jump_ID(jump_ID),
        .Address_ID_EX(Address_ID_EX), .RegWrite_ID_EX(RegWrite_ID_EX), .MemRead_ID_EX(MemRead_ID_EX),
        .Address_EX_MEM(Address_EX_MEM), .RegWrite_EX_MEM(RegWrite_EX_MEM), .MemRead_EX_MEM(MemRead_EX_MEM),
        .md_start(md_start), .exc_req(exc_req),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Flush(EX_MEM_Flush),
        .exc_pc_sel(exc_pc_sel), .md_done(md_done), .stall_count(stall_count)
    );

    hazard_controller #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .uses_rs(uses_rs), .uses_rt(uses_rt),
        .is_branch_ID(is_branch_ID), .branch_taken(branch_taken), .jump_ID(jump_ID),
        .Address_ID_EX(Address_ID_EX), .RegWrite_ID_EX(RegWrite_ID_EX), .MemRead_ID_EX(MemRead_ID_EX),
        .Address_EX_MEM(Address_EX_MEM), .RegWrite_EX_MEM(RegWrite_EX_MEM), .MemRead_EX_MEM(MemRead_EX_MEM),
        .md_start(md_start), .exc_req(exc_req),
        .PC_Write(s_pc), .IF_ID_Write(s_ifw), .ID_EX_Write(s_idw),
        .IF_ID_Flush(s_iff), .ID_EX_Flush(s_idf), .EX_MEM_Flush(s_exf),
        .exc_pc_sel(s_exc), .md_done(s_done), .stall_count(s_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        Rs_ID = '0; Rt_ID = '0; uses_rs = 1'b0; uses_rt = 1'b0;
        is_branch_ID = 1'b0; branch_taken = 1'b0; jump_ID = 1'b0;
        Address_ID_EX = '0; RegWrite_ID_EX = 1'b0; MemRead_ID_EX = 1'b0;
        Address_EX_MEM = '0; RegWrite_EX_MEM = 1'b0; MemRead_EX_MEM = 1'b0;
        md_start = 1'b0; exc_req = 1'b0;
    endtask

    // Advance one full clock; inputs are applied just after the falling edge
    // and outputs sampled 2 ns later, well away from the rising edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_data_stall(input string tag);
        #2;
        check({tag, "_pc"}, PC_Write, 1'b0);
        check({tag, "_ifw"}, IF_ID_Write, 1'b0);
        check({tag, "_idf"}, ID_EX_Flush, 1'b1);
    endtask

    task automatic expect_no_stall(input string tag);
        #2;
        check({tag, "_pc"}, PC_Write, 1'b1);
        check({tag, "_idf"}, ID_EX_Flush, 1'b0);
    endtask

    // One full MD_CYCLES=8 op with jump_ID held to show redirects are masked.
    task automatic run_md(input string tag);
        md_start = 1'b1;
        jump_ID  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #2;
            check({tag, "_hold_pc"}, PC_Write, 1'b0);
            check({tag, "_hold_idw"}, ID_EX_Write, 1'b0);
            check({tag, "_hold_exf"}, EX_MEM_Flush, 1'b1);
            check({tag, "_hold_iff"}, IF_ID_Flush, 1'b0);
            check({tag, "_hold_done"}, md_done, 1'b0);
            tick();
        end
        #2;
        check({tag, "_done"}, md_done, 1'b1);
        check({tag, "_done_pc"}, PC_Write, 1'b1);
        check({tag, "_done_exf"}, EX_MEM_Flush, 1'b0);
        tick();
        md_start = 1'b0;
        jump_ID  = 1'b0;
        #2;
        check({tag, "_after_done"}, md_done, 1'b0);
        check({tag, "_after_pc"}, PC_Write, 1'b1);
        tick();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #2;
        check("rst_pc", PC_Write, 1'b0);
        check("rst_ifw", IF_ID_Write, 1'b0);
        check("rst_idw", ID_EX_Write, 1'b0);
        check("rst_flush", {IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, exc_pc_sel, md_done}, 5'b0);
        check("rst_cnt", stall_count, 32'd0);
        tick();
        reset = 1'b0;

        // Idle defaults
        #2;
        check("idle_writes", {PC_Write, IF_ID_Write, ID_EX_Write}, 3'b111);
        check("idle_flush", {IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, exc_pc_sel, md_done}, 5'b0);
        tick();

        // Load-use: lw $8 in ID/EX, add $9,$8,$1 in ID
        MemRead_ID_EX = 1'b1; RegWrite_ID_EX = 1'b1; Address_ID_EX = 5'd8;
        Rs_ID = 5'd8; uses_rs = 1'b1; Rt_ID = 5'd1; uses_rt = 1'b1;
        expect_data_stall("lu");
        check("lu_idw", ID_EX_Write, 1'b1);
        tick();
        MemRead_ID_EX = 1'b0; RegWrite_ID_EX = 1'b0; Address_ID_EX = '0;
        MemRead_EX_MEM = 1'b1; RegWrite_EX_MEM = 1'b1; Address_EX_MEM = 5'd8;
        expect_no_stall("lu2");
        check("lu_cnt", stall_count, 32'd1);
        tick();
        clear_inputs();

        // Branch on load: beq $8,$0 after lw $8 -> 2 stalls, then taken
        is_branch_ID = 1'b1; Rs_ID = 5'd8; uses_rs = 1'b1; Rt_ID = 5'd0; uses_rt = 1'b1;
        MemRead_ID_EX = 1'b1; RegWrite_ID_EX = 1'b1; Address_ID_EX = 5'd8;
        expect_data_stall("bl1");
        tick();
        MemRead_ID_EX = 1'b0; RegWrite_ID_EX = 1'b0; Address_ID_EX = '0;
        MemRead_EX_MEM = 1'b1; RegWrite_EX_MEM = 1'b1; Address_EX_MEM = 5'd8;
        expect_data_stall("bl2");
        tick();
        MemRead_EX_MEM = 1'b0; RegWrite_EX_MEM = 1'b0; Address_EX_MEM = '0;
        branch_taken = 1'b1;
        expect_no_stall("bl3");
        check("bl_iff", IF_ID_Flush, 1'b1);
        check("bl_cnt", stall_count, 32'd3);
        tick();
        clear_inputs();
        #2;
        check("bl_iff_once", IF_ID_Flush, 1'b0);
        tick();

        // Branch on ALU result through Rt: 2 stalls
        is_branch_ID = 1'b1; Rt_ID = 5'd9; uses_rt = 1'b1;
        RegWrite_ID_EX = 1'b1; Address_ID_EX = 5'd9;
        expect_data_stall("brt1");
        tick();
        RegWrite_ID_EX = 1'b0; Address_ID_EX = '0;
        RegWrite_EX_MEM = 1'b1; Address_EX_MEM = 5'd9;
        expect_data_stall("brt2");
        tick();
        clear_inputs();

        // Branch on ALU result through Rs: 1 stall (EX/MEM forwards Rs)
        is_branch_ID = 1'b1; Rs_ID = 5'd10; uses_rs = 1'b1;
        RegWrite_ID_EX = 1'b1; Address_ID_EX = 5'd10;
        expect_data_stall("brs1");
        tick();
        RegWrite_ID_EX = 1'b0; Address_ID_EX = '0;
        RegWrite_EX_MEM = 1'b1; Address_EX_MEM = 5'd10;
        expect_no_stall("brs2");
        check("br_cnt", stall_count, 32'd6);
        tick();
        clear_inputs();

        // Register-zero guard and unused-source guard
        MemRead_ID_EX = 1'b1; Address_ID_EX = 5'd0; Rs_ID = 5'd0; uses_rs = 1'b1;
        expect_no_stall("zero");
        tick();
        Address_ID_EX = 5'd12; Rs_ID = 5'd12; uses_rs = 1'b0;
        expect_no_stall("unused");
        tick();
        clear_inputs();

        // Redirect masked by a data stall, then honoured alone
        MemRead_ID_EX = 1'b1; Address_ID_EX = 5'd3; Rs_ID = 5'd3; uses_rs = 1'b1;
        branch_taken = 1'b1;
        expect_data_stall("mask");
        check("mask_iff", IF_ID_Flush, 1'b0);
        tick();
        clear_inputs();
        jump_ID = 1'b1;
        #2;
        check("jump_iff", IF_ID_Flush, 1'b1);
        check("jump_cnt", stall_count, 32'd7);
        tick();
        clear_inputs();

        // Mult/div: 8 hold cycles, md_done on the ninth
        run_md("md");
        check("md_cnt", stall_count, 32'd15);

        // Exception abort at cycle 3 of MD_BUSY
        md_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("abort_hold", PC_Write, 1'b0);
            tick();
        end
        exc_req = 1'b1;
        #2;
        check("exc_flush", {IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, exc_pc_sel}, 4'b1111);
        check("exc_pc", PC_Write, 1'b1);
        check("exc_done", md_done, 1'b0);
        tick();
        clear_inputs();
        for (int i = 0; i < 10; i++) begin
            #2;
            check("abort_run_pc", PC_Write, 1'b1);
            check("abort_no_done", md_done, 1'b0);
            tick();
        end
        check("abort_cnt", stall_count, 32'd18);

        // Exception beats a data stall in RUN and is not counted
        MemRead_ID_EX = 1'b1; Address_ID_EX = 5'd4; Rs_ID = 5'd4; uses_rs = 1'b1;
        exc_req = 1'b1;
        #2;
        check("exc_run_pc", PC_Write, 1'b1);
        check("exc_run_flush", {IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, exc_pc_sel}, 4'b1111);
        tick();
        clear_inputs();
        #2;
        check("exc_run_cnt", stall_count, 32'd18);
        tick();

        // Asynchronous reset mid-MD_BUSY, between clock edges
        md_start = 1'b1;
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        check("areset_writes", {PC_Write, IF_ID_Write, ID_EX_Write}, 3'b000);
        check("areset_flush", {IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, exc_pc_sel, md_done}, 5'b0);
        check("areset_cnt", stall_count, 32'd0);
        check("areset_sat_cnt", s_count, 4'd0);
        tick();
        clear_inputs();
        reset = 1'b0;
        #2;
        check("post_rst_pc", PC_Write, 1'b1);
        check("post_rst_done", md_done, 1'b0);
        check("post_rst_cnt", stall_count, 32'd0);
        tick();

        // Saturation: two 8-cycle ops into a 4-bit counter
        run_md("sat1");
        check("sat1_cnt", s_count, 4'd8);
        run_md("sat2");
        check("sat2_cnt", s_count, 4'hF);
        check("wide_cnt", stall_count, 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
